gf_inv_sched: RTL
=================

Name: gf_inv_sched

Overview:
- Round-robin scheduler that shares one GF(2^M) inversion datapath between NREQ requesters, e.g. point-add, point-double and the affine-conversion units.
- Captures one requester's operand and issues a one-cycle start to the inverter. Waits for the inverter's done, guarded by a cycle timeout. Returns the result to the owning requester with a one-cycle response pulse.
- Sits between the ECC point-arithmetic controllers and the inverse datapath. Drives the reduction polynomial to the datapath as a constant.

Parameters:
- M, 4, field width in bits; the polynomial is M+1 bits.
- NREQ, 3, number of requesters (2..8).
- POLY, 5'b10011, irreducible polynomial driven on inv_f (x^4+x+1).
- TIMEOUT, 16, maximum WAIT cycles before an error response (>=2).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request level
- req_a  in  NREQ*M  packed operands; requester i owns bits [i*M +: M]
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse
- rsp_data  out  M  inverse result; valid only while rsp_valid is non-zero
- rsp_err  out  1  qualifies rsp_valid: timeout (or zero operand when the optional feature is built in)
- busy  out  1  high in every state except IDLE
- inv_start  out  1  one-cycle start pulse to the inverter
- inv_a  out  M  operand held stable from ISSUE through WAIT
- inv_f  out  M+1  constant POLY
- inv_done  in  1  inverter completion pulse or level; sampled only in WAIT
- inv_out  in  M  inverter result, sampled on the cycle inv_done is high

Behaviour:
- Reset values (async, immediate): state IDLE, rr_ptr 0, rsp_valid 0, rsp_data 0, rsp_err 0, busy 0, inv_start 0, inv_a 0, timeout counter 0. inv_f is constant POLY.
- Reset mid-operation aborts the transaction. No response is issued and the inverter result is ignored.
- Request handshake: a requester raises req[i] and holds req_a[i] stable until it sees rsp_valid[i]. It must drop req[i] in the cycle after rsp_valid[i], or the level is taken as a new request.
- Arbitration: in IDLE, scan from rr_ptr upward with wrap at NREQ-1 to 0, and grant the first asserted req.
- On grant: latch owner index and operand; rr_ptr <= owner+1 (mod NREQ).
- FSM transitions:
  - IDLE -> ISSUE when any req is high.
  - ISSUE (1 cycle): inv_start=1, inv_a=latched operand; -> WAIT. Counter cleared.
  - WAIT: if inv_done, capture inv_out -> RESP with err=0. Otherwise, if counter==TIMEOUT-1, -> RESP with err=1 and data 0. Otherwise counter++.
  - RESP (1 cycle): rsp_valid[owner]=1, rsp_data/rsp_err registered; -> IDLE.
- Latency: request seen in IDLE at cycle 0 -> ISSUE at cycle 1. The earliest response is cycle 3 (done on the first WAIT cycle), so latency is 3 + inverter cycles.
- Withdrawal: if req[owner] drops during ISSUE or WAIT, finish WAIT normally but suppress rsp_valid (RESP still lasts 1 cycle).
- Simultaneous requests: exactly one grant per transaction. Others wait; fairness is guaranteed by rr_ptr rotation.
- Late done: inv_done arriving while not in WAIT is ignored.
- Back-to-back: IDLE is mandatory between transactions, so a new inv_start occurs no earlier than 2 cycles after RESP. This guarantees the inverter sees a fresh start.

Optional Feature:
- Macro: GF_INV_ZERO_CHK_EN.
- Defined: in ISSUE, an operand of 0 skips inv_start and goes straight to RESP with rsp_err=1 and rsp_data=0. Total latency is 3 cycles.
- Undefined: zero is issued to the inverter and normally ends in timeout.

Decomposition:
- Shared package gf_pkg:
  - field width M and polynomial POLY constants;
  - FSM state enum {IDLE, ISSUE, WAIT, RESP};
  - field element typedef.
- One natural sub-module: gf_rr_arb, a combinational round-robin priority picker (req vector, rr_ptr in; grant index and valid out).

Test Plan:
- Single request, a=4'b1111 on requester 0, model inverter with done after 5 cycles -> rsp_valid=3'b001, rsp_data=4'b1000, rsp_err=0, 8 cycles after req.
- All three requesters high at once with a=4'b0100/4'b1001/4'b0010 -> responses in order 0,1,2 with data 4'b1101, 4'b0010, 4'b1001. Exactly one inv_start per transaction.
- Inverter model never asserts done, TIMEOUT=16 -> RESP after 16 WAIT cycles with rsp_err=1, rsp_data=0. busy then falls.
- Reset pulsed during WAIT -> all outputs 0 immediately. A later inv_done produces no rsp_valid; the next request is served normally from rr_ptr=0.
- req[1] dropped during WAIT -> no rsp_valid bit set. The next grant goes to requester 2 before requester 0.
- With GF_INV_ZERO_CHK_EN, a=4'b0000 -> no inv_start, rsp_err=1 at cycle 3. Without it, the bench's model inverter never completes, and the response is rsp_err=1 at timeout.

Source files
------------

// File: rtl/gf_pkg.sv
// gf_pkg: shared GF(2^4) field constants, element type and scheduler state encoding
package gf_pkg;
    localparam int GF_M = 4;
    localparam logic [GF_M:0] GF_POLY = 5'b10011;
    typedef logic [GF_M-1:0] gf_elem_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/gf_rr_arb.sv
// gf_rr_arb: combinational round-robin picker, first asserted req at or above ptr with wrap
module gf_rr_arb #(
    parameter int NREQ = 3,
    parameter int W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [W-1:0]    ptr,
    output logic [W-1:0]    gnt,
    output logic            vld
);
    logic [W-1:0] j;
    always_comb begin
        gnt = '0;
        j = '0;
        vld = |req;
        // walk downward so the candidate closest to ptr is written last and wins
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % NREQ);
            if (req[j]) gnt = j;
        end
    end
endmodule

// File: rtl/gf_inv_sched.sv
// gf_inv_sched: round-robin sharing of one GF(2^M) inverter between NREQ requesters
// GF_INV_ZERO_CHK_EN: zero operands are answered with an error without starting the inverter
module gf_inv_sched
    import gf_pkg::*;
#(
    parameter int M = GF_M,
    parameter int NREQ = 3,
    parameter logic [M:0] POLY = GF_POLY,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*M-1:0] req_a,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [M-1:0]      rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              inv_start,
    output logic [M-1:0]      inv_a,
    output logic [M:0]        inv_f,
    input  logic              inv_done,
    input  logic [M-1:0]      inv_out
);
    localparam int W = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    state_t state;
    logic [W-1:0] rr_ptr, own, gnt;
    logic [CW-1:0] cnt;
    logic gv, keep, keep_n, zf, done_ok;
    logic [M-1:0] op;

    gf_rr_arb #(.NREQ(NREQ), .W(W)) u_arb (.req(req), .ptr(rr_ptr), .gnt(gnt), .vld(gv));

    assign inv_f = POLY;
    assign op = req_a[int'(gnt)*M +: M];
    // keep tracks whether the owner has held its request since the grant
    assign keep_n = keep & req[own];
    assign done_ok = inv_done & ~zf;
`ifndef GF_INV_ZERO_CHK_EN
    assign zf = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            own <= '0;
            keep <= 1'b0;
            cnt <= '0;
            rsp_valid <= '0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
            busy <= 1'b0;
            inv_start <= 1'b0;
            inv_a <= '0;
`ifdef GF_INV_ZERO_CHK_EN
            zf <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (gv) begin
                    state <= ISSUE;
                    own <= gnt;
                    keep <= 1'b1;
                    rr_ptr <= (gnt == W'(NREQ - 1)) ? '0 : gnt + 1'b1;
                    busy <= 1'b1;
                    inv_a <= op;
`ifdef GF_INV_ZERO_CHK_EN
                    inv_start <= |op;
`else
                    inv_start <= 1'b1;
`endif
                end
                ISSUE: begin
                    state <= WAIT;
                    inv_start <= 1'b0;
                    cnt <= '0;
                    keep <= keep_n;
`ifdef GF_INV_ZERO_CHK_EN
                    zf <= ~|inv_a;
`endif
                end
                WAIT: begin
                    keep <= keep_n;
                    if (done_ok || zf || cnt == CW'(TIMEOUT - 1)) begin
                        state <= RESP;
                        rsp_valid <= keep_n ? NREQ'(1) << own : '0;
                        rsp_data <= done_ok ? inv_out : '0;
                        rsp_err <= ~done_ok;
                    end else cnt <= cnt + 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                    rsp_valid <= '0;
                    rsp_data <= '0;
                    rsp_err <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
